// File: rtl/cam_fb_arbiter.sv
// Frame-buffer RAM arbiter: queues capture pixels, interleaves them with CPU/display reads,
// and counts frames. Define CAM_FB_DOUBLE_BUFFER_EN for ping-pong banks on mem_addr[17].
module cam_fb_arbiter #(
    parameter int FB_W     = 320,
    parameter int FB_H     = 240,
    parameter int QLOG     = 3,
    parameter int HI_WATER = 6,
    parameter int STARVE   = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] cap_dout,
    input  logic [9:0]  cap_addr_x,
    input  logic [9:0]  cap_addr_y,
    input  logic        cap_en,
    input  logic        rd_req,
    input  logic [9:0]  rd_addr_x,
    input  logic [9:0]  rd_addr_y,
    output logic        rd_ack,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        mem_en,
    output logic        mem_we,
    output logic [17:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        frame_done,
    output logic [7:0]  frame_cnt,
    output logic [15:0] drop_cnt
);
    localparam int QDEPTH = 1 << QLOG;
    localparam int SW     = $clog2(STARVE + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR     = 2'd1,
        RD     = 2'd2,
        RDWAIT = 2'd3
    } state_t;

    // y*FB_W + x; the default width reduces to two shifts and an add
    function automatic logic [16:0] lin_addr(input logic [9:0] x, input logic [9:0] y);
        logic [16:0] xe;
        logic [16:0] ye;
        xe = {7'd0, x};
        ye = {7'd0, y};
        if (FB_W == 320) begin
            lin_addr = (ye << 8) + (ye << 6) + xe;
        end else begin
            lin_addr = ye * 17'(FB_W) + xe;
        end
    endfunction

    state_t          state_r;
    state_t          state_next_s;
    logic [15:0]     q_data_r [QDEPTH];
    logic [16:0]     q_addr_r [QDEPTH];
    logic            q_last_r [QDEPTH];
    logic [QLOG-1:0] wr_ptr_r;
    logic [QLOG-1:0] rd_ptr_r;
    logic [QLOG:0]   level_r;
    logic [SW-1:0]   starve_r;
    logic            in_range_s;
    logic            cap_last_s;
    logic            q_full_s;
    logic            q_empty_s;
    logic            push_s;
    logic            rd_ok_s;
    logic            grant_rd_s;
    logic            grant_wr_s;
    logic            wr_bank_s;
    logic            rd_bank_s;

    assign in_range_s = (cap_addr_x < 10'(FB_W)) && (cap_addr_y < 10'(FB_H));
    assign cap_last_s = (cap_addr_x == 10'(FB_W - 1)) && (cap_addr_y == 10'(FB_H - 1));
    assign q_full_s   = (level_r == (QLOG + 1)'(QDEPTH));
    assign q_empty_s  = (level_r == (QLOG + 1)'(0));
    // A same-cycle pop never frees a slot for the incoming pixel
    assign push_s     = cap_en && in_range_s && !q_full_s;
    assign rd_ok_s    = rd_req && (state_r != RD) && (state_r != RDWAIT) &&
                        ((level_r < (QLOG + 1)'(HI_WATER)) || (starve_r >= SW'(STARVE)));

`ifdef CAM_FB_DOUBLE_BUFFER_EN
    logic wbank_r;

    // Bank flips the cycle after frame_done; grants in that cycle already use the new bank
    always_ff @(posedge CLK) begin
        if (RST) begin
            wbank_r <= 1'b0;
        end else if (frame_done) begin
            wbank_r <= ~wbank_r;
        end else begin
            wbank_r <= wbank_r;
        end
    end

    assign wr_bank_s = wbank_r ^ frame_done;
    assign rd_bank_s = ~wr_bank_s;
`else
    assign wr_bank_s = 1'b0;
    assign rd_bank_s = 1'b0;
`endif

    // Grant decision: read first when allowed, else drain the queue
    always_comb begin
        grant_rd_s   = 1'b0;
        grant_wr_s   = 1'b0;
        state_next_s = IDLE;
        case (state_r)
            RD: begin
                state_next_s = RDWAIT;
            end
            IDLE, WR, RDWAIT: begin
                if (rd_ok_s) begin
                    grant_rd_s   = 1'b1;
                    state_next_s = RD;
                end else if (!q_empty_s) begin
                    grant_wr_s   = 1'b1;
                    state_next_s = WR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Queue payload; address is linearised at push time
    always_ff @(posedge CLK) begin
        if (push_s) begin
            q_data_r[wr_ptr_r] <= cap_dout;
            q_addr_r[wr_ptr_r] <= lin_addr(cap_addr_x, cap_addr_y);
            q_last_r[wr_ptr_r] <= cap_last_s;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + QLOG'(1);
            end
            if (grant_wr_s) begin
                rd_ptr_r <= rd_ptr_r + QLOG'(1);
            end
            if (push_s && !grant_wr_s) begin
                level_r <= level_r + (QLOG + 1)'(1);
            end else if (!push_s && grant_wr_s) begin
                level_r <= level_r - (QLOG + 1)'(1);
            end
        end
    end

    // Starvation counter and saturating drop counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_r <= '0;
            drop_cnt <= 16'd0;
        end else begin
            if (!rd_req || grant_rd_s) begin
                starve_r <= '0;
            end else if (grant_wr_s && (starve_r < SW'(STARVE))) begin
                starve_r <= starve_r + SW'(1);
            end
            if (cap_en && !push_s && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // State register, RAM port, read handshake and frame tracking
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= IDLE;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 18'd0;
            mem_wdata  <= 16'd0;
            rd_ack     <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= 16'd0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            state_r    <= state_next_s;
            rd_ack     <= grant_rd_s;
            rd_valid   <= (state_r == RDWAIT);
            frame_done <= grant_wr_s && q_last_r[rd_ptr_r];
            if (state_r == RDWAIT) begin
                rd_data <= mem_rdata;
            end
            if (grant_wr_s && q_last_r[rd_ptr_r]) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (grant_rd_s) begin
                mem_en   <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= {rd_bank_s, lin_addr(rd_addr_x, rd_addr_y)};
            end else if (grant_wr_s) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= {wr_bank_s, q_addr_r[rd_ptr_r]};
                mem_wdata <= q_data_r[rd_ptr_r];
            end else begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cam_fb_arbiter.sv
// Directed bench for cam_fb_arbiter: pixel vector table plus read, starvation/overflow and reset sequences.
module tb_cam_fb_arbiter;
    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] cap_dout;
    logic [9:0]  cap_addr_x;
    logic [9:0]  cap_addr_y;
    logic        cap_en;
    logic        rd_req;
    logic [9:0]  rd_addr_x;
    logic [9:0]  rd_addr_y;
    logic        rd_ack;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        mem_en;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'd0;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic [15:0] drop_cnt;

    logic        pre_we;
    logic [17:0] pre_addr;
    logic [15:0] pre_data;
    logic [15:0] ram [0:262143];

`ifdef CAM_FB_DOUBLE_BUFFER_EN
    localparam logic DB = 1'b1;
`else
    localparam logic DB = 1'b0;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] d;
        logic        en;
        logic [16:0] addr;
        logic        bank;
        logic        fd;
        logic [7:0]  fcnt;
        logic [15:0] drop;
    } vec_t;
    vec_t vecs [9];

    logic       ack_seen  [0:60];
    logic       we_seen   [0:60];
    logic [15:0] drop_seen [0:60];

    cam_fb_arbiter dut (
        .CLK(CLK), .RST(RST),
        .cap_dout(cap_dout), .cap_addr_x(cap_addr_x), .cap_addr_y(cap_addr_y), .cap_en(cap_en),
        .rd_req(rd_req), .rd_addr_x(rd_addr_x), .rd_addr_y(rd_addr_y),
        .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 CLK = ~CLK;

    // Single-port synchronous-read RAM with a bench-side preload port
    always @(posedge CLK) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_en && !mem_we) begin
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] all_outs();
        all_outs = {1'b0, rd_ack, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata,
                    frame_done, frame_cnt, drop_cnt};
    endfunction

    initial begin
        int n_ack;
        int n_wr;
        int n_wr_starve;
        int n_valid;
        logic bad_valid;
        logic bad_en;

        vecs[0] = '{10'd5,    10'd2,    16'hABCD, 1'b1, 17'd645,   1'b0, 1'b0, 8'd0, 16'd0};
        vecs[1] = '{10'd0,    10'd0,    16'h0001, 1'b1, 17'd0,     1'b0, 1'b0, 8'd0, 16'd0};
        vecs[2] = '{10'd319,  10'd0,    16'h1111, 1'b1, 17'd319,   1'b0, 1'b0, 8'd0, 16'd0};
        vecs[3] = '{10'd0,    10'd239,  16'h2222, 1'b1, 17'd76480, 1'b0, 1'b0, 8'd0, 16'd0};
        vecs[4] = '{10'd320,  10'd0,    16'h3333, 1'b0, 17'd0,     1'b0, 1'b0, 8'd0, 16'd1};
        vecs[5] = '{10'd0,    10'd240,  16'h4444, 1'b0, 17'd0,     1'b0, 1'b0, 8'd0, 16'd2};
        vecs[6] = '{10'd1023, 10'd1023, 16'h4545, 1'b0, 17'd0,     1'b0, 1'b0, 8'd0, 16'd3};
        vecs[7] = '{10'd319,  10'd239,  16'hBEEF, 1'b1, 17'd76799, 1'b0, 1'b1, 8'd1, 16'd3};
        vecs[8] = '{10'd10,   10'd10,   16'h5555, 1'b1, 17'd3210,  1'b1, 1'b0, 8'd1, 16'd3};

        RST = 1'b1; cap_dout = 16'd0; cap_addr_x = 10'd0; cap_addr_y = 10'd0; cap_en = 1'b0;
        rd_req = 1'b0; rd_addr_x = 10'd0; rd_addr_y = 10'd0;
        pre_we = 1'b1; pre_addr = 18'h00180; pre_data = 16'h1234;
        step();
        pre_we = 1'b0;
        step();
        step();
        check("reset_outputs", all_outs(), 80'd0);
        RST = 1'b0;

        // Pixel vectors: push at cycle t, RAM port observed at t+2
        for (int i = 0; i < 9; i++) begin
            cap_addr_x = vecs[i].x; cap_addr_y = vecs[i].y; cap_dout = vecs[i].d; cap_en = 1'b1;
            step();
            cap_en = 1'b0;
            step();
            check($sformatf("v%0d_mem_en", i), {79'd0, mem_en}, {79'd0, vecs[i].en});
            if (vecs[i].en) begin
                check($sformatf("v%0d_mem_we", i), {79'd0, mem_we}, 80'd1);
                check($sformatf("v%0d_addr", i), {63'd0, mem_addr[16:0]}, {63'd0, vecs[i].addr});
                check($sformatf("v%0d_bank", i), {79'd0, mem_addr[17]}, {79'd0, DB ? vecs[i].bank : 1'b0});
                check($sformatf("v%0d_wdata", i), {64'd0, mem_wdata}, {64'd0, vecs[i].d});
            end
            check($sformatf("v%0d_frame_done", i), {79'd0, frame_done}, {79'd0, vecs[i].fd});
            check($sformatf("v%0d_frame_cnt", i), {72'd0, frame_cnt}, {72'd0, vecs[i].fcnt});
            check($sformatf("v%0d_drop_cnt", i), {64'd0, drop_cnt}, {64'd0, vecs[i].drop});
            step();
        end

        // Read path: request at t, ack at t+1, data at t+3, held afterwards
        rd_addr_x = 10'h040; rd_addr_y = 10'd1; rd_req = 1'b1;
        step();
        check("rd_ack_t1", {79'd0, rd_ack}, 80'd1);
        check("rd_mem_cmd_t1", {60'd0, mem_en, mem_we, mem_addr}, {60'd0, 1'b1, 1'b0, 18'h00180});
        rd_req = 1'b0;
        step();
        check("rd_t2_quiet", {78'd0, rd_ack, rd_valid}, 80'd0);
        step();
        check("rd_valid_t3", {79'd0, rd_valid}, 80'd1);
        check("rd_data_t3", {64'd0, rd_data}, 80'h1234);
        step();
        check("rd_hold_t4", {63'd0, rd_valid, rd_data}, {63'd0, 1'b0, 16'h1234});

        // Starvation and overflow: pixel every cycle, read request held high
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        for (int cyc = 0; cyc <= 60; cyc++) begin
            ack_seen[cyc]  = rd_ack;
            we_seen[cyc]   = mem_en && mem_we;
            drop_seen[cyc] = drop_cnt;
            if (rd_valid) begin
                n_valid++;
            end
            cap_en = (cyc <= 44);
            cap_addr_x = 10'(cyc); cap_addr_y = 10'd10; cap_dout = 16'(cyc);
            rd_req = (cyc <= 42);
            step();
        end
        cap_en = 1'b0; rd_req = 1'b0;
        n_ack = 0; n_wr = 0; n_wr_starve = 0;
        for (int c = 0; c <= 60; c++) begin
            n_ack += int'(ack_seen[c]);
            n_wr  += int'(we_seen[c]);
            if (c >= 9 && c <= 24) begin
                n_wr_starve += int'(we_seen[c]);
            end
        end
        check("starve_writes_before_read", 80'(n_wr_starve), 80'd16);
        check("starve_forced_ack_c25", {79'd0, ack_seen[25]}, 80'd1);
        check("starve_second_ack_c43", {79'd0, ack_seen[43]}, 80'd1);
        check("ack_count", 80'(n_ack), 80'd5);
        check("valid_count", 80'(n_valid), 80'd5);
        check("write_count", 80'(n_wr), 80'd42);
        check("drop_c26", {64'd0, drop_seen[26]}, 80'd0);
        check("drop_c27", {64'd0, drop_seen[27]}, 80'd1);
        check("drop_c44", {64'd0, drop_seen[44]}, 80'd2);
        check("drop_total", {64'd0, drop_cnt}, 80'd3);

        // Reset one cycle after rd_ack abandons the read and flushes the queue
        rd_addr_x = 10'h040; rd_addr_y = 10'd1; rd_req = 1'b1;
        cap_addr_x = 10'd1; cap_addr_y = 10'd1; cap_dout = 16'h7777; cap_en = 1'b1;
        step();
        check("rst_read_ack", {79'd0, rd_ack}, 80'd1);
        rd_req = 1'b0; cap_en = 1'b0;
        step();
        RST = 1'b1;
        step();
        check("rst_mid_read_outputs", all_outs(), 80'd0);
        RST = 1'b0;
        bad_valid = 1'b0; bad_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            bad_valid = bad_valid | rd_valid;
            bad_en = bad_en | mem_en;
        end
        check("rst_no_rd_valid", {79'd0, bad_valid}, 80'd0);
        check("rst_queue_flushed", {79'd0, bad_en}, 80'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
